// File: rtl/polygon_pkg.sv
// polygon_pkg: shared definitions for the polygon_area block.
//   - default geometry (COORD_W_DEF, N_POINTS_DEF, ACC_W_DEF)
//   - FSM state encoding (IDLE=0, ACCUM=1, CLOSE=2, DONE=3)
//   - vertex_t: one {x,y} vertex at the default coordinate width
package polygon_pkg;

    localparam int COORD_W_DEF  = 8;
    localparam int N_POINTS_DEF = 6;
    localparam int ACC_W_DEF    = 2 * COORD_W_DEF + 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        CLOSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic [COORD_W_DEF-1:0] x;
        logic [COORD_W_DEF-1:0] y;
    } vertex_t;

endpackage

// File: rtl/polygon_area_cross_term.sv
// cross_term: combinational signed 2D determinant T(a,b) = a.x*b.y - b.x*a.y.
// Ports:
//   i_a_x, i_a_y  vertex a, unsigned COORD_W
//   i_b_x, i_b_y  vertex b, unsigned COORD_W
//   o_t           signed ACC_W result
// Operands are zero-extended to ACC_W before multiplying, so each product is
// non-negative and only the final subtraction carries a sign.
module cross_term #(
    parameter int COORD_W = 8,
    parameter int ACC_W   = 2 * COORD_W + 4
) (
    input  logic [COORD_W-1:0]      i_a_x,
    input  logic [COORD_W-1:0]      i_a_y,
    input  logic [COORD_W-1:0]      i_b_x,
    input  logic [COORD_W-1:0]      i_b_y,
    output logic signed [ACC_W-1:0] o_t
);

    logic [ACC_W-1:0] w_ax;
    logic [ACC_W-1:0] w_ay;
    logic [ACC_W-1:0] w_bx;
    logic [ACC_W-1:0] w_by;
    logic [ACC_W-1:0] w_p0;
    logic [ACC_W-1:0] w_p1;

    assign w_ax = ACC_W'(i_a_x);
    assign w_ay = ACC_W'(i_a_y);
    assign w_bx = ACC_W'(i_b_x);
    assign w_by = ACC_W'(i_b_y);
    assign w_p0 = w_ax * w_by;
    assign w_p1 = w_bx * w_ay;
    // Two's-complement difference; bit pattern is identical signed or unsigned.
    assign o_t  = $signed(w_p0 - w_p1);

endmodule

// File: rtl/polygon_area.sv
// polygon_area: shoelace-formula area of an ordered polygon vertex stream.
// One vertex is accepted per cycle when in_valid && in_ready; after N_POINTS
// vertices the polygon is closed (last -> first) and |S| is reported as
// area = floor(|S|/2) plus area_half = |S|[0], with a one-cycle out_valid.
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   in_valid   vertex present on inX/inY
//   inX, inY   vertex coordinates, unsigned COORD_W
//   in_ready   vertex accepted this cycle if in_valid (IDLE/ACCUM only)
//   area       floor(|S|/2), 2*COORD_W+2 bits
//   area_half  |S| bit 0
//   out_valid  one-cycle result strobe
//   orient     (only with POLYGON_AREA_ORIENT_EN) 1 = clockwise, 0 = CCW/zero
// Handshake: a transfer happens on a rising edge where in_valid and in_ready
// are both high; in_valid while in_ready is low is dropped, never buffered.
// Optional feature macro: POLYGON_AREA_ORIENT_EN.
module polygon_area
    import polygon_pkg::*;
#(
    parameter int N_POINTS = N_POINTS_DEF,
    parameter int COORD_W  = COORD_W_DEF,
    parameter int ACC_W    = 2 * COORD_W + 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    input  logic [COORD_W-1:0]     inX,
    input  logic [COORD_W-1:0]     inY,
    output logic                   in_ready,
    output logic [2*COORD_W+1:0]   area,
    output logic                   area_half,
    output logic                   out_valid
`ifdef POLYGON_AREA_ORIENT_EN
    ,
    output logic                   orient
`endif
);

    localparam int CNT_W  = 4;
    localparam int AREA_W = 2 * COORD_W + 2;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
    } vtx_t;

    state_t                  r_state;
    logic [CNT_W-1:0]        r_cnt;
    logic signed [ACC_W-1:0] r_acc;
    vtx_t                    r_first;
    vtx_t                    r_prev;
    logic [AREA_W-1:0]       r_area;
    logic                    r_area_half;
    logic                    r_out_valid;
`ifdef POLYGON_AREA_ORIENT_EN
    logic                    r_orient;
`endif

    vtx_t                    w_v;
    vtx_t                    w_b;
    logic                    w_accept;
    logic signed [ACC_W-1:0] w_t;
    logic signed [ACC_W-1:0] w_mag;

    assign w_v = '{x: inX, y: inY};

    // in_ready is gated by reset so it reads 0 while reset is held even
    // though the state register already sits in IDLE.
    assign in_ready = reset & ((r_state == IDLE) | (r_state == ACCUM));
    assign w_accept = in_valid & in_ready;

    // Single determinant unit: second operand is the new vertex while
    // accumulating, and the first vertex when closing the polygon.
    assign w_b = (r_state == CLOSE) ? r_first : w_v;

    cross_term #(
        .COORD_W (COORD_W),
        .ACC_W   (ACC_W)
    ) u_cross_term (
        .i_a_x (r_prev.x),
        .i_a_y (r_prev.y),
        .i_b_x (w_b.x),
        .i_b_y (w_b.y),
        .o_t   (w_t)
    );

    assign w_mag = r_acc[ACC_W-1] ? -r_acc : r_acc;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_acc       <= '0;
            r_first     <= '0;
            r_prev      <= '0;
            r_area      <= '0;
            r_area_half <= 1'b0;
            r_out_valid <= 1'b0;
`ifdef POLYGON_AREA_ORIENT_EN
            r_orient    <= 1'b0;
`endif
        end else begin
            r_out_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_first <= w_v;
                        r_prev  <= w_v;
                        r_acc   <= '0;
                        r_cnt   <= CNT_W'(1);
                        r_state <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (w_accept) begin
                        r_acc  <= r_acc + w_t;
                        r_prev <= w_v;
                        r_cnt  <= r_cnt + CNT_W'(1);
                        // r_cnt counts vertices before this one.
                        if (r_cnt == CNT_W'(N_POINTS - 1)) begin
                            r_state <= CLOSE;
                        end
                    end
                end
                CLOSE: begin
                    r_acc   <= r_acc + w_t;
                    r_state <= DONE;
                end
                DONE: begin
                    r_area      <= AREA_W'(w_mag >>> 1);
                    r_area_half <= w_mag[0];
                    r_out_valid <= 1'b1;
`ifdef POLYGON_AREA_ORIENT_EN
                    r_orient    <= r_acc[ACC_W-1];
`endif
                    r_state     <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign area      = r_area;
    assign area_half = r_area_half;
    assign out_valid = r_out_valid;
`ifdef POLYGON_AREA_ORIENT_EN
    assign orient    = r_orient;
`endif

endmodule

// File: tb/tb_polygon_area.sv
// Directed bench for polygon_area: hand-computed shoelace results for a set
// of six-vertex polygons, reset behaviour and back-to-back streaming.
module tb_polygon_area;

    localparam int COORD_W = 8;
    localparam int NP      = 6;
    localparam int AREA_W  = 2 * COORD_W + 2;

    logic               clk;
    logic               reset;
    logic               in_valid;
    logic [COORD_W-1:0] inX;
    logic [COORD_W-1:0] inY;
    logic               in_ready;
    logic [AREA_W-1:0]  area;
    logic               area_half;
    logic               out_valid;
`ifdef POLYGON_AREA_ORIENT_EN
    logic               orient;
`endif

    polygon_area #(
        .N_POINTS (NP),
        .COORD_W  (COORD_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .inX       (inX),
        .inY       (inY),
        .in_ready  (in_ready),
        .area      (area),
        .area_half (area_half),
        .out_valid (out_valid)
`ifdef POLYGON_AREA_ORIENT_EN
        ,
        .orient    (orient)
`endif
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_errors = 0;

    // Scoreboard entries: {orient, area_half, area}
    logic [AREA_W+1:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // ---------------- vertex tables ----------------
    logic [7:0] rect_x  [NP] = '{0, 4, 8, 8, 4, 0};
    logic [7:0] rect_y  [NP] = '{0, 0, 0, 6, 6, 6};
    logic [7:0] rectr_x [NP] = '{0, 4, 8, 8, 4, 0};
    logic [7:0] rectr_y [NP] = '{6, 6, 6, 0, 0, 0};
    logic [7:0] tri_x   [NP] = '{0, 1, 2, 3, 0, 0};
    logic [7:0] tri_y   [NP] = '{0, 0, 0, 0, 3, 1};
    logic [7:0] trir_x  [NP] = '{0, 0, 3, 2, 1, 0};
    logic [7:0] trir_y  [NP] = '{1, 3, 0, 0, 0, 0};
    logic [7:0] max_x   [NP] = '{0, 255, 255, 0, 0, 0};
    logic [7:0] max_y   [NP] = '{0, 0, 255, 255, 255, 255};

    // ---------------- driver tasks ----------------
    // All driving happens 1 time unit after a rising edge; in_ready is
    // settled there and decides whether the next edge transfers.
    task automatic send_vertex(input logic [7:0] x, input logic [7:0] y);
        int guard;
        in_valid = 1'b1;
        inX      = x;
        inY      = y;
        guard    = 0;
        while (!in_ready && guard < 20) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (!in_ready) check("ready_wait", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_polygon(input logic [7:0] xs [NP], input logic [7:0] ys [NP], input int gap);
        for (int i = 0; i < NP; i++) begin
            send_vertex(xs[i], ys[i]);
            if (gap > 0 && i < NP - 1) idle_cycles(gap);
        end
    endtask

    task automatic push_exp(input int a, input logic h, input logic o);
        exp_q.push_back({o, h, AREA_W'(a)});
    endtask

    // Called 1 unit after the edge that took the last vertex (edge k).
    // out_valid must be low after k and k+1, high after k+2, low after k+3.
    task automatic finish_polygon(input string tag);
        logic [AREA_W+1:0] e;
        in_valid = 1'b0;
        check({tag, "_ready_close"}, {31'd0, in_ready}, 32'd0);
        check({tag, "_ov_k"}, {31'd0, out_valid}, 32'd0);
        @(posedge clk); #1;
        check({tag, "_ov_k1"}, {31'd0, out_valid}, 32'd0);
        @(posedge clk); #1;
        check({tag, "_ov_k2"}, {31'd0, out_valid}, 32'd1);
        if (exp_q.size() == 0) begin
            check({tag, "_exp_q_empty"}, 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_area"}, 32'(area), 32'(e[AREA_W-1:0]));
            check({tag, "_half"}, {31'd0, area_half}, {31'd0, e[AREA_W]});
`ifdef POLYGON_AREA_ORIENT_EN
            check({tag, "_orient"}, {31'd0, orient}, {31'd0, e[AREA_W+1]});
`endif
        end
        @(posedge clk); #1;
        check({tag, "_ov_k3"}, {31'd0, out_valid}, 32'd0);
        check({tag, "_area_hold"}, 32'(area), 32'(e[AREA_W-1:0]));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset    = 1'b0;
        in_valid = 1'b0;
        inX      = '0;
        inY      = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_area", 32'(area), 32'd0);
        check("rst_half", {31'd0, area_half}, 32'd0);
        check("rst_ov", {31'd0, out_valid}, 32'd0);
        check("rst_ready", {31'd0, in_ready}, 32'd0);
        reset = 1'b1;
        #1;
        check("idle_ready", {31'd0, in_ready}, 32'd1);

        // CCW rectangle: S = 96
        push_exp(48, 1'b0, 1'b0);
        send_polygon(rect_x, rect_y, 0);
        finish_polygon("rect_ccw");

        // Same rectangle clockwise: S = -96
        push_exp(48, 1'b0, 1'b1);
        send_polygon(rectr_x, rectr_y, 0);
        finish_polygon("rect_cw");

        // Triangle with collinear extras, random gaps between vertices: S = 9
        push_exp(4, 1'b1, 1'b0);
        send_polygon(tri_x, tri_y, int'($urandom_range(1, 3)));
        finish_polygon("tri_gap");

        // Maximum extent square with duplicates: S = 130050
        push_exp(65025, 1'b0, 1'b0);
        send_polygon(max_x, max_y, 0);
        finish_polygon("max");

        // Partial polygon discarded by a mid-stream reset
        for (int i = 0; i < 3; i++) send_vertex(rect_x[i], rect_y[i]);
        in_valid = 1'b0;
        reset    = 1'b0;
        #1;
        check("mid_rst_area", 32'(area), 32'd0);
        check("mid_rst_ready", {31'd0, in_ready}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("mid_rst_ov", {31'd0, out_valid}, 32'd0);
        reset = 1'b1;
        #1;
        push_exp(48, 1'b0, 1'b0);
        send_polygon(rect_x, rect_y, 0);
        finish_polygon("after_rst");

        // Two polygons back to back: the second's first vertex is held on the
        // bus through CLOSE/DONE and must only be taken on the out_valid cycle.
        push_exp(48, 1'b0, 1'b0);
        push_exp(4, 1'b1, 1'b1);
        send_polygon(rect_x, rect_y, 0);
        in_valid = 1'b1;
        inX      = trir_x[0];
        inY      = trir_y[0];
        check("b2b_ready_close", {31'd0, in_ready}, 32'd0);
        @(posedge clk); #1;
        check("b2b_ready_done", {31'd0, in_ready}, 32'd0);
        check("b2b_ov_k1", {31'd0, out_valid}, 32'd0);
        @(posedge clk); #1;
        check("b2b_ov_k2", {31'd0, out_valid}, 32'd1);
        check("b2b_ready_ov", {31'd0, in_ready}, 32'd1);
        begin
            logic [AREA_W+1:0] e;
            e = exp_q.pop_front();
            check("b2b_first_area", 32'(area), 32'(e[AREA_W-1:0]));
            check("b2b_first_half", {31'd0, area_half}, {31'd0, e[AREA_W]});
        end
        send_polygon(trir_x, trir_y, 0);
        finish_polygon("b2b_second");

        check("exp_q_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/polygon_area.md
Name: polygon_area

Overview:
- Downstream consumer of the hull/ordering stage; takes the ordered vertex stream (one X/Y pair per valid cycle) and computes the enclosed polygon area with the shoelace formula.
- Accumulates one cross term per accepted vertex, closes the polygon (last vertex back to first), and emits the magnitude with a one-cycle out_valid pulse.
- Sits between the vertex-ordering block and result reporting / the testbench.

Parameters:
- N_POINTS, 6, vertices per polygon (range 3..15).
- COORD_W, 8, unsigned coordinate width.
- ACC_W, 2*COORD_W+4, signed accumulator width (20 at default).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- in_valid  in  1  vertex present on inX/inY this cycle.
- inX  in  COORD_W  vertex X, unsigned.
- inY  in  COORD_W  vertex Y, unsigned.
- in_ready  out  1  block accepts a vertex this cycle.
- area  out  2*COORD_W+2  floor(|S|/2), where S is the shoelace sum.
- area_half  out  1  |S| bit 0 (true area = area + 0.5 when set).
- out_valid  out  1  one-cycle pulse; area/area_half are valid while it is high.

Behaviour:
- Reset (async, reset==0): state=IDLE, cnt=0, acc=0, first/prev registers=0, area=0, area_half=0, out_valid=0, in_ready=0 while reset is held.
- A vertex is accepted on a rising edge when in_valid && in_ready. in_valid while in_ready=0 is ignored; nothing is buffered.
- in_ready=1 in IDLE and ACCUM, 0 in CLOSE and DONE.
- Cross term T(a,b) = a.x*b.y - b.x*a.y.
  - Operands are zero-extended to ACC_W and the subtraction is signed.
  - No overflow is possible at the defaults; S magnitude is at most 6*65025.
- IDLE:
  - On acceptance: first<=v, prev<=v, acc<=0, cnt<=1 -> ACCUM.
  - out_valid deasserts the cycle after its pulse.
- ACCUM:
  - On acceptance: acc<=acc+T(prev,v), prev<=v, cnt<=cnt+1.
  - When the accepted vertex is number N_POINTS -> CLOSE.
- CLOSE (1 cycle, unconditional): acc<=acc+T(prev,first) -> DONE.
- DONE (1 cycle):
  - mag = acc<0 ? -acc : acc.
  - area<=mag>>1, area_half<=mag[0], out_valid<=1.
  - Returns to IDLE.
- Latency: last vertex accepted at edge k; out_valid is high for exactly the cycle following edge k+2.
- area/area_half hold their value until the next DONE. The next polygon's first vertex may be accepted in the cycle out_valid is high (IDLE).
- Boundary conditions:
  - Degenerate, collinear or duplicate vertices give area=0 or a correct partial area; no error is flagged.
  - Clockwise order (S<0) gives the same magnitude as counter-clockwise.
  - Reset asserted mid-stream discards the partial polygon; the next vertex after release starts a new polygon.
  - Gaps in in_valid between vertices are allowed and impose no timeout.

Optional Feature:
- Macro POLYGON_AREA_ORIENT_EN.
- Defined:
  - Adds output port `orient` (1 bit): registered in DONE as the sign bit of acc (1 = clockwise, 0 = CCW or zero).
  - Reset value of `orient` is 0.
  - `orient` updates only with out_valid.
- Undefined: the port and its register are absent; all other behaviour is identical.

Decomposition:
- Package polygon_pkg holds:
  - COORD_W, N_POINTS and ACC_W defaults.
  - The state encoding: IDLE=0, ACCUM=1, CLOSE=2, DONE=3, 2-bit.
  - The vertex struct typedef {x,y}.
- One sub-module, cross_term: combinational signed determinant T(a,b) at ACC_W.
  - Used once, with a mux selecting (prev,v) in ACCUM and (prev,first) in CLOSE.

Test Plan:
- CCW rectangle (0,0),(4,0),(8,0),(8,6),(4,6),(0,6), back-to-back valid -> area=48, area_half=0, out_valid exactly 3 edges after the 6th vertex.
- Same vertices in reverse (clockwise) -> area=48, area_half=0; with POLYGON_AREA_ORIENT_EN, orient=1 (0 for the CCW case).
- Triangle with extras (0,0),(1,0),(2,0),(3,0),(0,3),(0,1) -> area=4, area_half=1.
- Max extent (0,0),(255,0),(255,255),(0,255),(0,255),(0,255) -> area=65025, area_half=0, no overflow.
- 3 vertices, then reset low for 2 cycles, then the full rectangle -> outputs 0 during reset, then area=48; in_valid held high through CLOSE/DONE is ignored (in_ready=0) and does not corrupt cnt.
- Two polygons streamed with the second's first vertex presented on the out_valid cycle -> both results correct, second out_valid at the expected latency.
